// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM sharing one ALU, one memory port and the register file.
// Latency: outputs are a combinational decode of the current state plus op/funct/zero; the state advances every clock.
// Backpressure: none by default; with MEM_WAIT_EN defined, FETCH/MEMRD/MEMWR stall on mem_ready.
// Optional feature macro: MEM_WAIT_EN (adds input mem_ready and memory wait states).
// Ports: clk, reset (sync, active-high); op/funct from the IR; zero from the ALU;
//        pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
//        signext, shiftl16, pcsrc, alucontrol, illegal, state (debug).
module mc_controller #(
  parameter int ILLEGAL_TRAP = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       signext,
  output logic       shiftl16,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t st;
  logic   mrdy;
  logic   funct_ok;
  logic [2:0] funct_alu;

`ifdef MEM_WAIT_EN
  assign mrdy = mem_ready;
`else
  assign mrdy = 1'b1;
`endif

  assign state = st;

  // R-type function decode, shared by the EXEC outputs and the EXEC exit.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_AND;
    case (funct)
      6'b100000, 6'b100001: funct_alu = ALU_ADD;
      6'b100010, 6'b100011: funct_alu = ALU_SUB;
      6'b100100:            funct_alu = ALU_AND;
      6'b100101:            funct_alu = ALU_OR;
      6'b101010, 6'b101011: funct_alu = ALU_SLT;
      default:              funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
    end else begin
      case (st)
        FETCH:  if (mrdy) st <= DECODE;
        DECODE: begin
          case (op)
            6'b000000:                                st <= EXEC;
            6'b100011, 6'b101011:                     st <= MEMADR;
            6'b000100, 6'b000101:                     st <= BRANCH;
            6'b001000, 6'b001001, 6'b001101, 6'b001111: st <= IEXEC;
            6'b000010:                                st <= JUMP;
            default:                                  st <= (ILLEGAL_TRAP != 0) ? HALT : FETCH;
          endcase
        end
        MEMADR: st <= (op == 6'b100011) ? MEMRD : MEMWR;
        MEMRD:  if (mrdy) st <= MEMWB;
        MEMWR:  if (mrdy) st <= FETCH;
        EXEC:   st <= funct_ok ? ALUWB : FETCH;
        IEXEC:  st <= IWB;
        HALT:   st <= HALT;
        default: st <= FETCH;   // MEMWB, ALUWB, BRANCH, IWB, JUMP and unused encodings
      endcase
    end
  end

  always_comb begin
    pcen       = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    signext    = 1'b0;
    shiftl16   = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    if (!reset) begin
      case (st)
        FETCH: begin
          // PC+4 computed while the instruction is read; both loads wait for memory.
          irwrite    = mrdy;
          pcen       = mrdy;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
        end
        DECODE: begin
          // Branch target precomputed into ALUOut.
          alusrcb    = 2'b11;
          signext    = 1'b1;
          alucontrol = ALU_ADD;
          case (op)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001001, 6'b001101, 6'b001111, 6'b000010: illegal = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
        MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          signext    = 1'b1;
          alucontrol = ALU_ADD;
        end
        MEMRD: iord = 1'b1;
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        EXEC: begin
          alusrca    = 1'b1;
          alucontrol = funct_alu;
          illegal    = ~funct_ok;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = (op == 6'b000101) ? ~zero : zero;
        end
        IEXEC: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          case (op)
            6'b001101: alucontrol = ALU_OR;
            6'b001111: begin
              shiftl16   = 1'b1;
              alucontrol = ALU_ADD;
            end
            default: begin
              signext    = 1'b1;
              alucontrol = ALU_ADD;
            end
          endcase
        end
        IWB: regwrite = 1'b1;
        JUMP: begin
          pcsrc = 2'b10;
          pcen  = 1'b1;
        end
        default: ;   // HALT and unused encodings drive nothing
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed instruction sequences against mc_controller with a scoreboard.
// Two instances: u0 with ILLEGAL_TRAP=0 and u1 with ILLEGAL_TRAP=1; the idle one is held in reset.
// Expected per-cycle output vectors are queued by the stimulus and checked by a monitor at negedge.
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       signext, shiftl16;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  typedef struct {
    int   id;
    logic sel;
    ctl_t v;
  } exp_t;

  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  logic [5:0] op = 6'b000000;
  logic [5:0] funct = 6'b100000;
  logic zero = 1'b0;
`ifdef MEM_WAIT_EN
  logic mem_ready = 1'b1;
`endif

  logic       pcen0, iord0, mw0, irw0, rdst0, mtr0, rw0, asa0, se0, sl0, ill0;
  logic [1:0] asb0, pcs0;
  logic [2:0] ac0;
  logic [3:0] st0;
  logic       pcen1, iord1, mw1, irw1, rdst1, mtr1, rw1, asa1, se1, sl1, ill1;
  logic [1:0] asb1, pcs1;
  logic [2:0] ac1;
  logic [3:0] st1;

  mc_controller #(.ILLEGAL_TRAP(0)) u0 (
    .clk(clk), .reset(reset0),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .iord(iord0), .memwrite(mw0), .irwrite(irw0), .regdst(rdst0),
    .memtoreg(mtr0), .regwrite(rw0), .alusrca(asa0), .alusrcb(asb0), .signext(se0),
    .shiftl16(sl0), .pcsrc(pcs0), .alucontrol(ac0), .illegal(ill0), .state(st0)
  );

  mc_controller #(.ILLEGAL_TRAP(1)) u1 (
    .clk(clk), .reset(reset1),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .op(op), .funct(funct), .zero(zero),
    .pcen(pcen1), .iord(iord1), .memwrite(mw1), .irwrite(irw1), .regdst(rdst1),
    .memtoreg(mtr1), .regwrite(rw1), .alusrca(asa1), .alusrcb(asb1), .signext(se1),
    .shiftl16(sl1), .pcsrc(pcs1), .alucontrol(ac1), .illegal(ill1), .state(st1)
  );

  ctl_t act0, act1;
  assign act0 = {st0, pcen0, iord0, mw0, irw0, rdst0, mtr0, rw0, asa0, asb0, se0, sl0, pcs0, ac0, ill0};
  assign act1 = {st1, pcen1, iord1, mw1, irw1, rdst1, mtr1, rw1, asa1, asb1, se1, sl1, pcs1, ac1, ill1};

  always #5 clk = ~clk;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_step = 0;

  function automatic ctl_t mk(input logic [3:0] s, input logic pe, input logic io, input logic mw,
                              input logic ir, input logic rd, input logic mt, input logic rw,
                              input logic sa, input logic [1:0] sb, input logic se, input logic sl,
                              input logic [1:0] ps, input logic [2:0] ac, input logic il);
    ctl_t c;
    c = {s, pe, io, mw, ir, rd, mt, rw, sa, sb, se, sl, ps, ac, il};
    return c;
  endfunction

  // Hand-written vectors for the fixed-output states.
  ctl_t x_zero0, x_fetch, x_decode, x_memadr, x_memrd, x_memwb, x_memwr, x_aluwb, x_iwb, x_jump, x_halt;
  initial begin
    //           st  pe io mw ir rd mt rw sa sb     se sl ps     ac      il
    x_zero0  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_fetch  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 3'b010, 0);
    x_decode = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00, 3'b010, 0);
    x_memadr = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 2'b00, 3'b010, 0);
    x_memrd  = mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_memwb  = mk(4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_memwr  = mk(5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_aluwb  = mk(7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_iwb    = mk(10,0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
    x_jump   = mk(11,1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 3'b000, 0);
    x_halt   = mk(12,0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0);
  end

  // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
  task automatic drive(input logic sel, input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input ctl_t e);
    exp_t x;
    reset0 = sel ? 1'b1 : rst;
    reset1 = sel ? rst : 1'b1;
    op = o;
    funct = f;
    zero = z;
    n_step++;
    x.id = n_step;
    x.sel = sel;
    x.v = e;
    q.push_back(x);
  endtask

  task automatic step(input logic sel, input logic rst, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input ctl_t e);
    @(posedge clk);
    #1;
    drive(sel, rst, o, f, z, e);
  endtask

`ifdef MEM_WAIT_EN
  task automatic stepm(input logic mr, input logic [5:0] o, input ctl_t e);
    @(posedge clk);
    #1;
    mem_ready = mr;
    drive(1'b0, 1'b0, o, 6'b100000, 1'b0, e);
  endtask
`endif

  // Monitor: every cycle with a queued expectation is compared at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      ctl_t a;
      x = q.pop_front();
      a = x.sel ? act1 : act0;
      n_cmp++;
      if (a !== x.v) begin
        n_bad++;
        $display("FAIL step%0d dut%0d: got st=%0d vec=%h, expected st=%0d vec=%h",
                 x.id, x.sel, a.st, a, x.v.st, x.v);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BNE = 6'b000101, LUI = 6'b001111;
  localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BAD = 6'b111111, ORI = 6'b001101, ADDI = 6'b001000;

  initial begin
    int waitc;
    // Reset held two cycles, then released.
    step(0, 1, LW, 6'b100000, 0, x_zero0);
    step(0, 1, LW, 6'b100000, 0, x_zero0);
    // LW: 0,1,2,3,4
    step(0, 0, LW, 6'b100000, 0, x_fetch);
    step(0, 0, LW, 6'b100000, 0, x_decode);
    step(0, 0, LW, 6'b100000, 0, x_memadr);
    step(0, 0, LW, 6'b100000, 0, x_memrd);
    step(0, 0, LW, 6'b100000, 0, x_memwb);
    // BNE not taken... zero=0 means operands differ, so BNE loads the PC.
    step(0, 0, BNE, 6'b100000, 0, x_fetch);
    step(0, 0, BNE, 6'b100000, 0, x_decode);
    step(0, 0, BNE, 6'b100000, 0, mk(8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b01, 3'b110, 0));
    step(0, 0, BNE, 6'b100000, 1, x_fetch);
    step(0, 0, BNE, 6'b100000, 1, x_decode);
    step(0, 0, BNE, 6'b100000, 1, mk(8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b01, 3'b110, 0));
    // LUI
    step(0, 0, LUI, 6'b100000, 0, x_fetch);
    step(0, 0, LUI, 6'b100000, 0, x_decode);
    step(0, 0, LUI, 6'b100000, 0, mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 2'b00, 3'b010, 0));
    step(0, 0, LUI, 6'b100000, 0, x_iwb);
    // R-type SUB
    step(0, 0, RT, 6'b100010, 0, x_fetch);
    step(0, 0, RT, 6'b100010, 0, x_decode);
    step(0, 0, RT, 6'b100010, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 3'b110, 0));
    step(0, 0, RT, 6'b100010, 0, x_aluwb);
    // R-type with unknown funct: flagged in EXEC, no writeback
    step(0, 0, RT, 6'b111111, 0, x_fetch);
    step(0, 0, RT, 6'b111111, 0, x_decode);
    step(0, 0, RT, 6'b111111, 0, mk(6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 2'b00, 3'b000, 1));
    // SW: 0,1,2,5
    step(0, 0, SW, 6'b100000, 0, x_fetch);
    step(0, 0, SW, 6'b100000, 0, x_decode);
    step(0, 0, SW, 6'b100000, 0, x_memadr);
    step(0, 0, SW, 6'b100000, 0, x_memwr);
    // J
    step(0, 0, J, 6'b100000, 0, x_fetch);
    step(0, 0, J, 6'b100000, 0, x_decode);
    step(0, 0, J, 6'b100000, 0, x_jump);
    // Unknown opcode without trap: pulse in DECODE, back to FETCH
    step(0, 0, BAD, 6'b100000, 0, x_fetch);
    step(0, 0, BAD, 6'b100000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00, 3'b010, 1));
    // ORI
    step(0, 0, ORI, 6'b100000, 0, x_fetch);
    step(0, 0, ORI, 6'b100000, 0, x_decode);
    step(0, 0, ORI, 6'b100000, 0, mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 2'b00, 3'b001, 0));
    step(0, 0, ORI, 6'b100000, 0, x_iwb);
    // LW interrupted by reset in MEMRD: outputs silenced at once, FETCH next edge
    step(0, 0, LW, 6'b100000, 0, x_fetch);
    step(0, 0, LW, 6'b100000, 0, x_decode);
    step(0, 0, LW, 6'b100000, 0, x_memadr);
    step(0, 1, LW, 6'b100000, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 3'b000, 0));
    // ADDI after reset release
    step(0, 0, ADDI, 6'b100000, 0, x_fetch);
    step(0, 0, ADDI, 6'b100000, 0, x_decode);
    step(0, 0, ADDI, 6'b100000, 0, mk(9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 2'b00, 3'b010, 0));
    step(0, 0, ADDI, 6'b100000, 0, x_iwb);
`ifdef MEM_WAIT_EN
    // Fetch stall, then SW with three wait cycles in MEMWR.
    stepm(0, SW, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 2'b00, 3'b010, 0));
    stepm(1, SW, x_fetch);
    stepm(1, SW, x_decode);
    stepm(1, SW, x_memadr);
    stepm(0, SW, x_memwr);
    stepm(0, SW, x_memwr);
    stepm(0, SW, x_memwr);
    stepm(1, SW, x_memwr);
    stepm(1, SW, x_fetch);
`endif
    // Trapping instance: unknown opcode parks in HALT until reset.
    step(1, 0, BAD, 6'b100000, 0, x_fetch);
    step(1, 0, BAD, 6'b100000, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 0, 2'b00, 3'b010, 1));
    for (int i = 0; i < 10; i++) step(1, 0, BAD, 6'b100000, 0, x_halt);
    step(1, 1, BAD, 6'b100000, 0, x_halt);
    step(1, 0, BAD, 6'b100000, 0, x_fetch);

    waitc = 0;
    while (q.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control FSM for the MIPS core. It sequences one shared ALU, one unified memory port and the register file across several cycles per instruction, in place of the single-cycle decoder. It sits beside the multicycle datapath and takes op/funct from the datapath's instruction register. It drives every mux select, write enable and ALU control, and the PC enable.

Parameters:
ILLEGAL_TRAP, 0, 0: an unknown opcode returns to FETCH; 1: the FSM enters HALT until reset.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag, same cycle
pcen  output  1  PC register load enable
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  write register select: 1 = rd, 0 = rt
memtoreg  output  1  writeback select: 1 = data reg, 0 = ALUOut
regwrite  output  1  register file write enable
alusrca  output  1  ALU A select: 0 = PC, 1 = rs
alusrcb  output  2  ALU B select: 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2
signext  output  1  immediate extension: 1 = sign, 0 = zero
shiftl16  output  1  shift the extended immediate left 16
pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
alucontrol  output  3  010 add, 110 sub, 001 or, 000 and, 111 slt
illegal  output  1  one-cycle pulse in DECODE on an unknown opcode
state  output  4  current state, for debug

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset is sampled on the rising edge only.
- Reset, including mid-instruction: state = FETCH (0) on the next edge. All enables and strobes (pcen, memwrite, irwrite, regwrite, illegal) are 0 while reset is high. All selects default to 0.
- Outputs are a combinational decode of state plus op/funct/zero. All outputs not listed for a state are 0.
- States and transitions:
  - FETCH(0): irwrite=1, alusrcb=01, alucontrol=add, pcen=1. Next: DECODE.
  - DECODE(1): alusrcb=11, signext=1, alucontrol=add (branch target into ALUOut). Next by op:
    - 000000 -> EXEC
    - 100011 or 101011 -> MEMADR
    - 000100 or 000101 -> BRANCH
    - 001000, 001001, 001101, 001111 -> IEXEC
    - 000010 -> JUMP
    - any other opcode -> illegal=1, then FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1).
  - MEMADR(2): alusrca=1, alusrcb=10, signext=1, add. Next: MEMRD for LW, MEMWR for SW.
  - MEMRD(3): iord=1. Next: MEMWB.
  - MEMWB(4): memtoreg=1, regwrite=1. Next: FETCH.
  - MEMWR(5): iord=1, memwrite=1. Next: FETCH.
  - EXEC(6): alusrca=1, alucontrol from funct:
    - 100000/100001 -> add
    - 100010/100011 -> sub
    - 100100 -> and
    - 100101 -> or
    - 101010/101011 -> slt
    - other funct -> illegal=1 in EXEC, no writeback, FETCH next.
    - Legal funct -> ALUWB next.
  - ALUWB(7): regdst=1, regwrite=1. Next: FETCH.
  - BRANCH(8): alusrca=1, sub, pcsrc=01. pcen = zero for BEQ, ~zero for BNE. Next: FETCH.
  - IEXEC(9): alusrca=1, alusrcb=10.
    - ADDI/ADDIU: signext=1, add.
    - ORI: signext=0, or.
    - LUI: signext=0, shiftl16=1, add.
    - Next: IWB.
  - IWB(10): regwrite=1 (regdst=0). Next: FETCH.
  - JUMP(11): pcsrc=10, pcen=1. Next: FETCH.
  - HALT(12): all strobes 0. Remains in HALT until reset.
  - Encodings 13–15: treated as FETCH next-state, with all outputs 0.
- CPI: LW 5, SW 4, R-type 4, I-type ALU 4, branch 3, jump 3.
- op/funct are read in every state (the IR holds them). The FSM does not latch them.

Optional Feature:
MEM_WAIT_EN:
- When defined, adds input mem_ready (1 bit).
- FETCH, MEMRD and MEMWR hold their state and all their outputs until mem_ready=1.
- pcen and irwrite in FETCH are gated by mem_ready.
- memwrite stays asserted through the wait.
- When not defined, memory is single-cycle and there is no mem_ready port.

Test Plan:
- Reset high 2 cycles, then release -> state=0, pcen=1, irwrite=1 in the first cycle. State sequence 0,1 follows.
- op=100011 (LW) -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. iord=1 in state 3.
- op=000101 (BNE):
  - zero=0 -> pcen=1, pcsrc=01 in state 8.
  - zero=1 -> pcen=0.
  - Next state is 0 in both cases.
- op=001111 (LUI) -> state 9 has shiftl16=1, signext=0, alusrcb=10. State 10 has regwrite=1, regdst=0.
- Unknown op:
  - op=111111 -> illegal=1 in state 1.
  - ILLEGAL_TRAP=0: next state 0.
  - ILLEGAL_TRAP=1: state 12 persists 10 cycles with regwrite=0 and memwrite=0 throughout; reset returns to state 0.
- With MEM_WAIT_EN, SW, mem_ready low 3 cycles in state 5 -> memwrite=1 for 4 cycles, then state 0. Also, reset asserted in state 3 -> state 0 on the next edge.
